// File: rtl/tteframe_ingress.sv
// Store-and-forward ingress buffer: receives byte-wide frames, keeps good ones in a
// 4 KiB data ring plus a 16-entry pointer FIFO, and drops runts, oversize and errored frames.
//
// state  | meaning
// S_IDLE | waiting for rx_dv; admission check runs on the first byte
// S_RECV | frame admitted, bytes written at wr_ptr; first rx_dv=0 cycle evaluates the frame
// S_DROP | frame rejected or oversize; wait for rx_dv=0, then count one drop
module tteframe_ingress #(
    parameter logic [3:0] PORT_MAP = 4'b0001,
    parameter int         MIN_LEN  = 60,
    parameter int         MAX_LEN  = 1518
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_dv,
    input  logic [7:0]  rx_data,
    input  logic        rx_er,
    input  logic        sfifo_rd,
    output logic [7:0]  sfifo_dout,
    input  logic        ptr_sfifo_rd,
    output logic [15:0] ptr_sfifo_dout,
    output logic        ptr_sfifo_empty,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [12:0] MAX_FREE = 13'(MAX_LEN);
    localparam logic [12:0] RAM_SIZE = 13'd4096;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_e;

    logic [7:0]  mem  [0:4095];
    logic [15:0] pmem [0:15];

    state_e      state_q, state_d;
    logic [12:0] wr_ptr_q, wr_ptr_d;
    logic [12:0] wr_commit_q, wr_commit_d;
    logic [12:0] rd_ptr_q;
    logic [4:0]  ptr_wr_q, ptr_rd_q;
    logic [10:0] len_q, len_d;
    logic        err_q, err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [7:0]  sfifo_dout_q;
    logic [15:0] ptr_dout_q;

    logic        mem_we;
    logic        ptr_push;
    logic        frame_inc;
    logic        drop_inc;
    logic [12:0] used_bytes;
    logic [12:0] free_bytes;
    logic [4:0]  ptr_count;
    logic        admit;
    logic        frame_ok;
    logic        ptr_empty;
    logic        data_avail;

    // Occupancy is measured against committed data only; an in-flight frame never
    // needs more than MAX_LEN bytes, so free >= MAX_LEN guarantees it fits.
    assign used_bytes = wr_commit_q - rd_ptr_q;
    assign free_bytes = RAM_SIZE - used_bytes;
    assign ptr_count  = ptr_wr_q - ptr_rd_q;
    assign admit      = (free_bytes >= MAX_FREE) && (ptr_count != 5'd16);
    assign frame_ok   = !err_q && (len_q >= MIN_L) && (len_q <= MAX_L);
    assign ptr_empty  = (ptr_wr_q == ptr_rd_q);
    assign data_avail = (rd_ptr_q != wr_commit_q);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        len_d       = len_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        ptr_push    = 1'b0;
        frame_inc   = 1'b0;
        drop_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_dv) begin
                    if (admit) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 13'd1;
                        len_d    = 11'd1;
                        err_d    = rx_er;
                        state_d  = S_RECV;
                    end else begin
                        state_d  = S_DROP;
                    end
                end
            end
            S_RECV: begin
                if (rx_dv) begin
                    if (len_q == MAX_L) begin
                        wr_ptr_d = wr_commit_q;
                        state_d  = S_DROP;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 13'd1;
                        len_d    = len_q + 11'd1;
                        err_d    = err_q | rx_er;
                    end
                end else begin
                    if (frame_ok) begin
                        wr_commit_d = wr_ptr_q;
                        ptr_push    = 1'b1;
                        frame_inc   = 1'b1;
                    end else begin
                        wr_ptr_d    = wr_commit_q;
                        drop_inc    = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (!rx_dv) begin
                    drop_inc = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        frame_cnt_d = (frame_inc && frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
        drop_cnt_d  = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            len_q       <= len_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage arrays are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[11:0]] <= rx_data;
        end
        if (ptr_push) begin
            pmem[ptr_wr_q[3:0]] <= {1'b0, PORT_MAP, len_q};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q     <= '0;
            ptr_wr_q     <= '0;
            ptr_rd_q     <= '0;
            sfifo_dout_q <= '0;
            ptr_dout_q   <= '0;
        end else begin
            if (sfifo_rd && data_avail) begin
                sfifo_dout_q <= mem[rd_ptr_q[11:0]];
                rd_ptr_q     <= rd_ptr_q + 13'd1;
            end
            if (ptr_sfifo_rd && !ptr_empty) begin
                ptr_dout_q <= pmem[ptr_rd_q[3:0]];
                ptr_rd_q   <= ptr_rd_q + 5'd1;
            end
            if (ptr_push) begin
                ptr_wr_q <= ptr_wr_q + 5'd1;
            end
        end
    end

    assign sfifo_dout      = sfifo_dout_q;
    assign ptr_sfifo_dout  = ptr_dout_q;
    assign ptr_sfifo_empty = ptr_empty;
    assign frame_cnt       = frame_cnt_q;
    assign drop_cnt        = drop_cnt_q;

endmodule

// File: doc/tteframe_ingress.md
TTEFRAME_INGRESS -- requirements
Module: tteframe_ingress

Interface
REQ-001 Parameter: PORT_MAP, 4'b0001, one-hot source port stamped into every pointer word.
REQ-002 Parameter: MIN_LEN, 60, minimum accepted frame length in bytes.
REQ-003 Parameter: MAX_LEN, 1518, maximum accepted frame length in bytes; SHALL be at most 2047.
REQ-004 Ports SHALL be, in order (name  direction  width  meaning):
 clk  in  1  single clock, all logic on rising edge;
 rstn  in  1  asynchronous active-low reset;
 rx_dv  in  1  receive byte valid, high for the whole frame (no preamble/SFD, FCS included);
 rx_data  in  8  receive byte;
 rx_er  in  1  receive error, sampled on every rx_dv cycle;
 sfifo_rd  in  1  data FIFO read strobe;
 sfifo_dout  out  8  data FIFO read byte;
 ptr_sfifo_rd  in  1  pointer FIFO read strobe;
 ptr_sfifo_dout  out  16  pointer word {1'b0, PORT_MAP[3:0], length[10:0]};
 ptr_sfifo_empty  out  1  no committed frame pending;
 frame_cnt  out  16  accepted frames, saturating;
 drop_cnt  out  16  dropped frames, saturating.

Function
REQ-005 The block SHALL hold a 4096x8 data RAM with 13-bit wr_ptr, wr_commit and rd_ptr (bit 12 = wrap bit), and a 16x16 pointer FIFO with 5-bit pointers.
REQ-006 The FSM SHALL have states IDLE, RECV and DROP.
REQ-007 In IDLE, when rx_dv=1, the block SHALL run the admission check in that same cycle: free = 4096-(wr_commit-rd_ptr) >= MAX_LEN and pointer FIFO count < 16.
REQ-008 On admit, the block SHALL write rx_data at wr_ptr in that cycle, set len=1, record err=rx_er and go to RECV; on reject it SHALL go to DROP and write nothing.
REQ-009 In RECV with rx_dv=1, the block SHALL write rx_data at wr_ptr, increment wr_ptr and len, and OR rx_er into err.
REQ-010 In RECV with rx_dv=1 and len already equal to MAX_LEN, the block SHALL discard the byte, roll back wr_ptr to wr_commit and go to DROP.
REQ-011 In RECV, the first cycle with rx_dv=0 SHALL be the evaluation cycle: the frame is good if err=0 and MIN_LEN <= len <= MAX_LEN.
REQ-012 A good frame SHALL set wr_commit<=wr_ptr, push {1'b0, PORT_MAP, len[10:0]}, increment frame_cnt and return to IDLE.
REQ-013 A bad frame SHALL set wr_ptr<=wr_commit, increment drop_cnt and return to IDLE.
REQ-014 DROP SHALL wait for rx_dv=0, increment drop_cnt once, and return to IDLE in that cycle.
REQ-015 Because IDLE is re-entered in the evaluation cycle, a new frame with rx_dv high the very next cycle (zero gap) SHALL be accepted normally.
REQ-016 ptr_sfifo_empty SHALL deassert in the cycle after the commit edge.
REQ-017 Read latency SHALL be one cycle: sfifo_rd=1 at edge N makes mem[rd_ptr] appear on sfifo_dout after edge N and increments rd_ptr; ptr_sfifo_rd behaves identically on the pointer FIFO.
REQ-018 sfifo_rd when rd_ptr==wr_commit, and ptr_sfifo_rd when empty, SHALL be ignored, with the outputs holding their values.
REQ-019 Uncommitted bytes SHALL never be readable.
REQ-020 A read and a commit in the same cycle SHALL both take effect; the empty flag SHALL reflect the net count.
REQ-021 Address arithmetic SHALL wrap modulo 4096, so a frame straddling address 4095->0 reads back contiguously.
REQ-022 frame_cnt and drop_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-023 rstn low SHALL asynchronously clear the state to IDLE, all pointers, len, err, sfifo_dout, ptr_sfifo_dout and both counters to 0, and set ptr_sfifo_empty=1.
REQ-024 RAM contents SHALL not be reset.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame.
REQ-026 After reset release, a frame already in progress (rx_dv high) SHALL be admitted from the current byte as a new frame; oversize and runt checks then decide its fate.

Verification
REQ-027 A 64-byte frame with bytes 0x00..0x3F SHALL give ptr word 16'h0840 (PORT_MAP=0001); reading 64 bytes SHALL return 0x00..0x3F; frame_cnt=1.
REQ-028 A 59-byte frame SHALL not change ptr_sfifo_empty (stays 1) and SHALL set drop_cnt=1; a following 60-byte frame SHALL be stored starting at address 0.
REQ-029 A 100-byte frame with rx_er on byte 50 SHALL be dropped, wr_ptr SHALL return to wr_commit, and a zero-gap 70-byte frame that follows SHALL commit with ptr length 70.
REQ-030 A 1600-byte frame SHALL be dropped after byte 1518, with no RAM pointer advance and drop_cnt incremented once.
REQ-031 Sixteen committed 60-byte frames left unread SHALL cause the 17th frame to be dropped; one ptr_sfifo_rd SHALL then allow the next frame to be admitted.
REQ-032 With rd_ptr=wr_commit=4000, a 200-byte frame SHALL wrap and read back intact; a reset asserted at byte 30 of a following frame SHALL leave ptr_sfifo_empty=1 and all counters at 0.
